// File: rtl/router_pkg.sv
// router_pkg: shared limits and counter-width helper for the router slice
package router_pkg;
  localparam int MAX_CH = 8;
  localparam int DEF_TIMEOUT = 30;
  function automatic int cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction
endpackage

// File: rtl/router_sync_param_if.sv
// router_sync_param_if: router control/status bundle between packet FSM, FIFOs and router
interface router_sync_param_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic                detect_add;
  logic [ADDR_W-1:0]   datain;
  logic                write_enb_reg;
  logic [NUM_CH-1:0]   read_enb;
  logic [NUM_CH-1:0]   empty;
  logic [NUM_CH-1:0]   full;
  logic                clr_status;
  logic [NUM_CH-1:0]   write_enb;
  logic                fifo_full;
  logic [NUM_CH-1:0]   vld_out;
  logic [NUM_CH-1:0]   soft_reset;
  logic                addr_err;
  logic [NUM_CH-1:0]   to_status;
  modport master (
    output detect_add, datain, write_enb_reg, read_enb, empty, full, clr_status,
    input  write_enb, fifo_full, vld_out, soft_reset, addr_err, to_status
  );
  modport slave (
    input  detect_add, datain, write_enb_reg, read_enb, empty, full, clr_status,
    output write_enb, fifo_full, vld_out, soft_reset, addr_err, to_status
  );
endinterface

// File: rtl/router_timeout_ch.sv
// router_timeout_ch: per-channel stall counter, soft-reset pulse and sticky timeout status
module router_timeout_ch
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic resetn,
  input  logic stall,
  input  logic clr_status,
  output logic soft_reset,
  output logic to_status
);
  localparam int CW = cnt_w(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          soft_reset_q, soft_reset_d;
  logic          to_status_q, to_status_d;
  logic          hit;
  always_comb begin
    hit          = stall && (cnt_q == CW'(TIMEOUT - 1));
    cnt_d        = (stall && !hit) ? cnt_q + 1'b1 : '0;
    soft_reset_d = hit;
    // a pulse landing together with clr_status must still be recorded
    to_status_d  = soft_reset_q | (to_status_q & ~clr_status);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
      to_status_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
      to_status_q  <= to_status_d;
    end
  end
  assign soft_reset = soft_reset_q;
  assign to_status  = to_status_q;
endmodule

// File: rtl/router_sync_param.sv
// router_sync_param: address decode, FIFO write steering and per-channel stall timeout
module router_sync_param
  import router_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ADDR_W  = 2
) (
  input  logic clk,
  input  logic resetn,
  router_sync_param_if.slave bus
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0] vld, stall, soft_reset, to_status, write_enb;
  logic              addr_err, fifo_full;
  always_comb begin
    addr_d    = bus.detect_add ? bus.datain : addr_q;
    vld       = ~bus.empty;
    stall     = vld & ~bus.read_enb;
    addr_err  = 32'(addr_q) >= NUM_CH;
    write_enb = '0;
    fifo_full = 1'b0;
    // an out-of-range address matches no channel, so both outputs stay low
    for (int i = 0; i < NUM_CH; i++) begin
      write_enb[i] = (32'(addr_q) == i) & bus.write_enb_reg & ~soft_reset[i];
      fifo_full    = fifo_full | ((32'(addr_q) == i) & bus.full[i]);
    end
  end
  always_ff @(posedge clk) addr_q <= !resetn ? '0 : addr_d;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_timeout_ch #(.TIMEOUT(TIMEOUT)) u_ch (
      .clk        (clk),
      .resetn     (resetn),
      .stall      (stall[g]),
      .clr_status (bus.clr_status),
      .soft_reset (soft_reset[g]),
      .to_status  (to_status[g])
    );
  end
  assign bus.write_enb  = write_enb;
  assign bus.fifo_full  = fifo_full;
  assign bus.vld_out    = vld;
  assign bus.soft_reset = soft_reset;
  assign bus.addr_err   = addr_err;
  assign bus.to_status  = to_status;
endmodule

// File: tb/tb_router_sync_param.sv
// tb_router_sync_param: directed scoreboard bench for 3- and 8-channel routers
module tb_router_sync_param;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  router_sync_param_if #(.NUM_CH(3), .ADDR_W(2)) b3 ();
  router_sync_param_if #(.NUM_CH(8), .ADDR_W(3)) b8 ();
  router_sync_param #(.NUM_CH(3), .TIMEOUT(30), .ADDR_W(2)) u3 (.clk(clk), .resetn(resetn), .bus(b3));
  router_sync_param #(.NUM_CH(8), .TIMEOUT(30), .ADDR_W(3)) u8 (.clk(clk), .resetn(resetn), .bus(b8));
  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed %0h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    b3.detect_add = 0; b3.datain = '0; b3.write_enb_reg = 0; b3.read_enb = '0;
    b3.empty = '1; b3.full = '0; b3.clr_status = 0;
    b8.detect_add = 0; b8.datain = '0; b8.write_enb_reg = 0; b8.read_enb = '0;
    b8.empty = '1; b8.full = '0; b8.clr_status = 0;
    tick(2);
    b3.write_enb_reg = 1;
    push("rst_addr_err", 0); push("rst_sr", 0); push("rst_ts", 0); push("rst_we", 3'b001);
    #1;
    chk(b3.addr_err); chk(b3.soft_reset); chk(b3.to_status); chk(b3.write_enb);
    resetn = 1;
    b3.detect_add = 1; b3.datain = 2;
    push("we_addr2", 3'b100); push("ff_addr2_clear", 0);
    tick();
    b3.detect_add = 0; b3.datain = 0;
    #1;
    chk(b3.write_enb); chk(b3.fifo_full);
    b3.full = 3'b100; push("ff_addr2_set", 1); #1; chk(b3.fifo_full);
    b3.full = 3'b011; push("ff_addr2_others", 0); #1; chk(b3.fifo_full);
    b3.write_enb_reg = 0; push("we_reg_low", 0); #1; chk(b3.write_enb);
    b3.detect_add = 1; b3.datain = 3; b3.write_enb_reg = 1; b3.full = 3'b111;
    push("err_flag", 1); push("err_we", 0); push("err_ff", 0);
    tick();
    b3.detect_add = 0; b3.datain = 0;
    #1;
    chk(b3.addr_err); chk(b3.write_enb); chk(b3.fifo_full);
    push("addr_hold", 1); tick(); chk(b3.addr_err);
    b3.empty = 3'b010; push("vld_out", 3'b101); #1; chk(b3.vld_out);
    b3.empty = '1; b3.full = '0;
    b3.detect_add = 1; b3.datain = 1;
    push("we_addr1", 3'b010);
    tick();
    b3.detect_add = 0;
    #1;
    chk(b3.write_enb);
    b3.empty = 3'b101;
    for (int k = 1; k <= 61; k++) begin
      push("sr1", (k == 30 || k == 60) ? 3'b010 : 3'b000);
      push("ts1", (k >= 31) ? 3'b010 : 3'b000);
      if (k >= 29 && k <= 31) push("we_mask", (k == 30) ? 3'b000 : 3'b010);
      tick();
      chk(b3.soft_reset); chk(b3.to_status);
      if (k >= 29 && k <= 31) chk(b3.write_enb);
    end
    b3.clr_status = 1; b3.read_enb = 3'b010;
    push("ts1_clear", 0); tick(); chk(b3.to_status);
    b3.clr_status = 0;
    b3.empty = 3'b110; b3.read_enb = '0;
    for (int k = 1; k <= 29; k++) begin
      push("sr0_a", 0); tick(); chk(b3.soft_reset);
    end
    b3.read_enb = 3'b001;
    push("sr0_break", 0); tick(); chk(b3.soft_reset);
    b3.read_enb = '0;
    for (int k = 1; k <= 29; k++) begin
      push("sr0_b", 0); tick(); chk(b3.soft_reset);
    end
    push("sr0_restart", 3'b001); tick(); chk(b3.soft_reset);
    push("ts0_after", 3'b001); tick(); chk(b3.to_status);
    b3.empty = '1;
    tick();
    b3.empty = 3'b110;
    tick(20);
    resetn = 0;
    tick();
    resetn = 1;
    push("rst_mid_ts", 0); push("rst_mid_we", 3'b001); #1;
    chk(b3.to_status); chk(b3.write_enb);
    for (int k = 1; k <= 30; k++) begin
      push("sr0_rst", (k == 30) ? 3'b001 : 3'b000); tick(); chk(b3.soft_reset);
    end
    b3.empty = '1;
    b8.detect_add = 1; b8.datain = 7; b8.write_enb_reg = 1;
    push("we8_addr7", 8'h80); push("err8", 0);
    tick();
    b8.detect_add = 0;
    #1;
    chk(b8.write_enb); chk(b8.addr_err);
    b8.empty = 8'h7e;
    for (int k = 1; k <= 30; k++) begin
      push("sr8", (k == 30) ? 8'h81 : 8'h00); tick(); chk(b8.soft_reset);
    end
    b8.clr_status = 1;
    push("ts8_set_wins", 8'h81); tick(); chk(b8.to_status);
    push("ts8_cleared", 8'h00); tick(); chk(b8.to_status);
    b8.clr_status = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_sync_param.md
ROUTER_SYNC_PARAM -- requirements
Module: router_sync_param

Interface
REQ-001 Parameter NUM_CH, default 3, number of output channels/FIFOs; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 30, consecutive stalled cycles before a channel soft reset; legal range 2..255.
REQ-003 Parameter ADDR_W, default 2, address field width; SHALL satisfy 2**ADDR_W >= NUM_CH.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 detect_add  in  1  header cycle; capture datain as destination address.
REQ-007 datain  in  ADDR_W  destination address from packet header.
REQ-008 write_enb_reg  in  1  FSM request to write current byte.
REQ-009 read_enb  in  NUM_CH  per-channel downstream read enable.
REQ-010 empty  in  NUM_CH  per-channel FIFO empty.
REQ-011 full  in  NUM_CH  per-channel FIFO full.
REQ-012 clr_status  in  1  clears sticky timeout status.
REQ-013 write_enb  out  NUM_CH  one-hot FIFO write enable.
REQ-014 fifo_full  out  1  full flag of addressed channel.
REQ-015 vld_out  out  NUM_CH  per-channel valid.
REQ-016 soft_reset  out  NUM_CH  per-channel single-cycle soft reset pulse.
REQ-017 addr_err  out  1  latched address >= NUM_CH.
REQ-018 to_status  out  NUM_CH  sticky record of channels that timed out.

Function
REQ-019 Address register SHALL load datain on a clock edge with detect_add=1, else hold.
REQ-020 addr_err, fifo_full, write_enb SHALL be combinational from the address register (zero latency after capture edge).
REQ-021 addr_err=1 when address >= NUM_CH; then fifo_full=0 and write_enb=0.
REQ-022 fifo_full SHALL equal full[address] for a valid address.
REQ-023 write_enb SHALL be one-hot bit [address] when write_enb_reg=1 and address valid, else all zero.
REQ-024 write_enb SHALL be zero for channel i in any cycle soft_reset[i]=1.
REQ-025 vld_out[i] SHALL equal ~empty[i], combinational.
REQ-026 Per channel, stall = vld_out[i] & ~read_enb[i]; counter cnt[i] (width clog2(TIMEOUT)) SHALL increment on each stall cycle.
REQ-027 Any non-stall cycle SHALL clear cnt[i] to 0 and keep soft_reset[i]=0 next cycle.
REQ-028 Stall cycle with cnt[i]==TIMEOUT-1 SHALL set soft_reset[i]=1 next cycle and clear cnt[i]; soft_reset[i]=1 exactly TIMEOUT cycles after stall begins.
REQ-029 soft_reset[i] SHALL be a registered one-cycle pulse; continued stall restarts counting from 0, next pulse TIMEOUT cycles later.
REQ-030 to_status[i] SHALL set on the cycle after soft_reset[i]=1 and hold until clr_status=1; simultaneous set and clear: set wins.
REQ-031 Channels SHALL operate independently; simultaneous timeouts on several channels all pulse in the same cycle.

Reset
REQ-032 resetn=0 at an edge SHALL clear address to 0, all cnt to 0, soft_reset to 0, to_status to 0.
REQ-033 Reset mid-count SHALL abort any pending pulse; counting restarts after resetn=1.
REQ-034 Combinational outputs after reset SHALL reflect address 0 (write_enb[0] follows write_enb_reg).

Structure
REQ-035 Package router_pkg SHALL hold MAX_CH=8, default TIMEOUT=30 and the clog2-based width helper.
REQ-036 Per-channel counter, pulse and sticky status SHALL be sub-module router_timeout_ch, instantiated NUM_CH times via generate.

Verification
REQ-037 NUM_CH=3: detect_add with datain=2, write_enb_reg=1 -> write_enb=3'b100; full[2]=1 -> fifo_full=1.
REQ-038 NUM_CH=3: datain=3 captured -> addr_err=1, write_enb=0, fifo_full=0 even with full=3'b111.
REQ-039 TIMEOUT=30: empty[1]=0, read_enb[1]=0 held 30 cycles -> soft_reset[1] high one cycle at cycle 30, to_status[1]=1 next cycle, again at cycle 60.
REQ-040 Stall 29 cycles, read_enb[0]=1 one cycle, stall 29 -> no soft_reset[0] pulse.
REQ-041 resetn=0 at stall cycle 20 -> cnt cleared, no pulse until 30 stall cycles after release.
REQ-042 NUM_CH=8, channels 0 and 7 stalled together -> both pulse same cycle; clr_status with set collision -> status remains 1.
